// File: rtl/aes_pipe_pkg.sv
// -----------------------------------------------------------------------------
// aes_pipe_pkg
// Shared definitions for the elastic register pipeline used between the
// unprotected AES datapath blocks.
//   - DEFAULT_WIDTH / DEFAULT_DEPTH : default geometry of the pipe
//   - clog2()                       : constant ceil(log2()) helper
//   - OCC_W                         : occupancy width for the default depth
//   - occ_op_e                      : update selector for the occupancy counter
// -----------------------------------------------------------------------------
package aes_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // ceil(log2(value)); clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Width of the occupancy count (0..DEPTH) for the default depth.
    localparam int OCC_W = clog2(DEFAULT_DEPTH + 1);

    // What the occupancy counter does on the next edge.
    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,   // no transfer, or accept and emit together
        OCC_INC  = 2'd1,   // accept only
        OCC_DEC  = 2'd2,   // emit only
        OCC_CLR  = 2'd3    // flush
    } occ_op_e;

endpackage

// File: rtl/elastic_dff_stage.sv
// -----------------------------------------------------------------------------
// elastic_dff_stage
// One stage of the elastic pipe: a WIDTH-bit data DFF and a valid DFF, both
// with asynchronous active-low reset, plus a load enable derived from the
// downstream ready.
//
// Ports
//   CK       in   1      clock, rising edge
//   RN       in   1      asynchronous reset, active low
//   flush    in   1      synchronous invalidate of this stage
//   v_in     in   1      valid presented by the upstream stage (or source)
//   d_in     in   WIDTH  data presented by the upstream stage (or source)
//   rdy_nxt  in   1      ready of the downstream stage (or sink)
//   v_q      out  1      valid flag of this stage
//   d_q      out  WIDTH  data register of this stage
//   rdy      out  1      this stage can take a word on the next edge
// -----------------------------------------------------------------------------
module elastic_dff_stage
    import aes_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             flush,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             rdy_nxt,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q,
    output logic             rdy
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;
    logic             w_load_d;

    // An empty stage is always ready, which is what squeezes bubbles out
    // while the sink stalls; a full stage is ready only if it can move on.
    assign rdy = ~r_v | rdy_nxt;

    // Data only moves when a real word arrives, so bubbles never toggle the
    // data register (the power trace must not depend on invalid data).
    assign w_load_d = rdy & ~flush & v_in;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value and the chain shifts by exactly one place.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_v <= 1'b0;
        end else if (flush) begin
            r_v <= 1'b0;
        end else if (rdy) begin
            r_v <= v_in;
        end
    end

    // NOTE: the data register is reset as well, not just the valid flag, so the
    // output shows RESET_VAL after reset instead of whatever was left behind.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_d <= RESET_VAL;
        end else if (w_load_d) begin
            r_d <= d_in;
        end
    end

    assign v_q = r_v;
    assign d_q = r_d;

endmodule

// File: rtl/elastic_dff_pipe.sv
// -----------------------------------------------------------------------------
// elastic_dff_pipe
// DEPTH-stage elastic register pipeline with valid/ready on both sides and
// bubble-collapsing backpressure. Used as the standard delay chain between
// unprotected AES datapath blocks.
//
// Ports
//   CK         in   1                 clock, rising edge
//   RN         in   1                 asynchronous reset, active low
//   flush      in   1                 synchronous: invalidate all stages
//   in_valid   in   1                 source offers in_data
//   in_ready   out  1                 pipe accepts this cycle
//   in_data    in   WIDTH             source data
//   out_valid  out  1                 last stage holds valid data
//   out_ready  in   1                 sink accepts this cycle
//   out_data   out  WIDTH             data of the last stage
//   occupancy  out  clog2(DEPTH+1)    number of valid stages (registered)
// -----------------------------------------------------------------------------
module elastic_dff_pipe
    import aes_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        CK,
    input  logic                        RN,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned          OCC_BITS = clog2(DEPTH + 1);
    localparam logic [OCC_BITS-1:0]  OCC_ONE  = OCC_BITS'(1);

    logic                r_run;     // set on the first edge after reset release
    logic [OCC_BITS-1:0] r_occ;
    logic                w_accept;
    logic                w_emit;
    occ_op_e             w_occ_op;

    // -------------------------------------------------------------------------
    // Stage chain. Each generate scope owns its own link signals so the ready
    // chain is a plain acyclic string of gates from the sink back to the source.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_v_in;
        logic [WIDTH-1:0] w_d_in;
        logic             w_rdy_nxt;
        logic             w_v;
        logic [WIDTH-1:0] w_d;
        logic             w_rdy;

        if (gi == 0) begin : g_head
            assign w_v_in = w_accept;
            assign w_d_in = in_data;
        end else begin : g_body
            assign w_v_in = g_stage[gi-1].w_v;
            assign w_d_in = g_stage[gi-1].w_d;
        end

        if (gi == DEPTH - 1) begin : g_tail
            assign w_rdy_nxt = out_ready;
        end else begin : g_link
            assign w_rdy_nxt = g_stage[gi+1].w_rdy;
        end

        elastic_dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CK      (CK),
            .RN      (RN),
            .flush   (flush),
            .v_in    (w_v_in),
            .d_in    (w_d_in),
            .rdy_nxt (w_rdy_nxt),
            .v_q     (w_v),
            .d_q     (w_d),
            .rdy     (w_rdy)
        );
    end

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // r_run keeps in_ready low through the first edge after RN rises, so the
    // edge that samples the reset release never carries a transfer.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign in_ready  = g_stage[0].w_rdy & ~flush & RN & r_run;
    assign out_valid = g_stage[DEPTH-1].w_v;
    assign out_data  = g_stage[DEPTH-1].w_d;

    assign w_accept  = in_valid & in_ready;
    assign w_emit    = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // Occupancy: tracks accepts minus emits. It cannot exceed DEPTH because an
    // accept into a full pipe only happens together with an emit.
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-chain can leave it unassigned and infer a latch.
    always_comb begin
        w_occ_op = OCC_HOLD;
        if (flush) begin
            w_occ_op = OCC_CLR;
        end else if (w_accept && !w_emit) begin
            w_occ_op = OCC_INC;
        end else if (!w_accept && w_emit) begin
            w_occ_op = OCC_DEC;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_occ <= '0;
        end else begin
            case (w_occ_op)
                OCC_INC:  r_occ <= r_occ + OCC_ONE;
                OCC_DEC:  r_occ <= r_occ - OCC_ONE;
                OCC_CLR:  r_occ <= '0;
                default:  r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_elastic_dff_pipe
// Scoreboard bench for elastic_dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0xC3).
// The driver pushes every accepted word into a queue; a separate monitor pops
// on every emit and compares. The reference model is the queue itself: its
// size is the occupancy, the pipe is full when it holds DEPTH words, and an
// unstalled word leaves exactly DEPTH cycles after it was accepted.
// -----------------------------------------------------------------------------
module tb_elastic_dff_pipe;
    import aes_pipe_pkg::*;

    localparam int               WIDTH     = 8;
    localparam int               DEPTH     = 4;
    localparam logic [WIDTH-1:0] RESET_VAL = 8'hC3;

    logic             CK        = 1'b0;
    logic             RN        = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
        bit               lat;
    } entry_t;

    entry_t           sb_q[$];      // accepted, not yet emitted, in order
    logic [WIDTH-1:0] src_q[$];     // words the source still wants to send

    int  n_cmp   = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  rn_last = 1'b0;            // RN as sampled by the latest rising edge
    bit  lat_chk = 1'b0;

    elastic_dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .CK        (CK),
        .RN        (RN),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 CK = ~CK;

    always @(negedge CK) cyc++;
    always @(posedge CK) rn_last = RN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: samples 1 time unit after the falling edge, when all inputs for
    // the coming rising edge are settled.
    // -------------------------------------------------------------------------
    initial begin : monitor
        entry_t           e;
        bit               prev_stall;
        logic [WIDTH-1:0] prev_data;
        bit               exp_rdy;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge CK);
            #1;
            if (!RN) begin
                check("reset_out_valid", out_valid, 0);
                check("reset_out_data", out_data, RESET_VAL);
                check("reset_in_ready", in_ready, 0);
                check("reset_occupancy", occupancy, 0);
                sb_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("occupancy", occupancy, sb_q.size());
                exp_rdy = rn_last && !flush && ((sb_q.size() < DEPTH) || out_ready);
                check("in_ready", in_ready, exp_rdy);
                if (prev_stall) begin
                    check("stall_out_valid", out_valid, 1);
                    check("stall_out_data", out_data, prev_data);
                end
                if (sb_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else if (out_valid && out_ready) begin
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    if (e.lat) check("latency", cyc - e.cyc, DEPTH);
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_data  = out_data;
                if (flush) sb_q.delete();
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver
    // -------------------------------------------------------------------------
    task automatic tick(input bit v, input bit ordy, input bit fl);
        entry_t e;
        @(negedge CK);
        in_valid  = v && (src_q.size() > 0);
        in_data   = (src_q.size() > 0) ? src_q[0] : WIDTH'($urandom);
        if (!in_valid) in_data = WIDTH'($urandom);
        out_ready = ordy;
        flush     = fl;
        #2;
        if (in_valid && in_ready) begin
            e.data = src_q.pop_front();
            e.cyc  = cyc;
            e.lat  = lat_chk;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || sb_q.size() > 0) && n < budget) begin
            tick(1'b1, 1'b1, 1'b0);
            n++;
        end
        check("drain_complete", src_q.size() + sb_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: run still going at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;

        // Reset held while the clock runs; the monitor checks reset outputs.
        repeat (3) @(negedge CK);
        RN = 1'b1;

        // Streaming: 0x01..0x10 back-to-back, sink always ready.
        lat_chk = 1'b1;
        for (int i = 1; i <= 16; i++) src_q.push_back(WIDTH'(i));
        n = 0;
        while (src_q.size() > 0 && n < 40) begin
            tick(1'b1, 1'b1, 1'b0);
            n++;
        end
        check("stream_cycles_for_16", n, 16);
        drain(20);
        lat_chk = 1'b0;

        // Stall fill: sink stalled, offer 0xA0..0xA5.
        for (int i = 0; i < 6; i++) src_q.push_back(8'hA0 + WIDTH'(i));
        repeat (6) tick(1'b1, 1'b0, 1'b0);
        check("fill_accepted", 6 - src_q.size(), 4);
        check("fill_occupancy", occupancy, 4);
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        check("fill_out_data", out_data, 8'hA0);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        drain(30);

        // Bubble collapse under stall: 0x11, two idle cycles, 0x22.
        src_q.push_back(8'h11);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        src_q.push_back(8'h22);
        tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        check("bubble_occupancy", occupancy, 2);
        check("bubble_out_valid", out_valid, 1);
        check("bubble_out_data", out_data, 8'h11);

        // Third word, then flush while 0x55 is offered.
        src_q.push_back(8'h33);
        tick(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("preflush_occupancy", occupancy, 3);
        src_q.push_back(8'h55);
        tick(1'b1, 1'b0, 1'b1);
        check("flush_in_ready", in_ready, 0);
        src_q.delete();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("flush_occupancy", occupancy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_data_held", out_data, 8'h11);
        src_q.push_back(8'h66);
        drain(20);

        // Random source, sink always ready: every word has latency DEPTH.
        lat_chk = 1'b1;
        repeat (300) begin
            if (src_q.size() == 0) src_q.push_back(WIDTH'($urandom));
            tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        drain(20);
        lat_chk = 1'b0;

        // Fully random traffic with occasional flush.
        repeat (2000) begin
            if (src_q.size() < 2) src_q.push_back(WIDTH'($urandom));
            tick($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 3);
        end
        drain(40);

        // Mid-operation reset while full and streaming.
        for (int i = 0; i < 10; i++) src_q.push_back(8'h70 + WIDTH'(i));
        repeat (6) tick(1'b1, 1'b1, 1'b0);
        #1;
        RN = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_data", out_data, RESET_VAL);
        check("midreset_occupancy", occupancy, 0);
        check("midreset_in_ready", in_ready, 0);
        src_q.delete();
        src_q.push_back(8'h90);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        @(negedge CK);
        RN = 1'b1;
        repeat (8) tick(1'b0, 1'b1, 1'b0);
        src_q.push_back(8'h91);
        drain(20);

        @(negedge CK);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
